// File: rtl/lc3b_fetch_if.sv
// lc3b_fetch_if: instruction-memory handshake and IR-side signals of the fetch stage
interface lc3b_fetch_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        ir_load;
  modport master (
    input  stall, redirect, redirect_pc, imem_resp, imem_rdata,
    output imem_read, imem_address, if_valid, if_instr, if_pc, if_pc_plus2, ir_load
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_resp, imem_rdata,
    input  imem_read, imem_address, if_valid, if_instr, if_pc, if_pc_plus2, ir_load
  );
endinterface

// File: rtl/lc3b_fetch.sv
// lc3b_fetch: LC-3b fetch stage owning the fetch PC, imem read handshake and IR hand-off
module lc3b_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic        clk,
  input logic        reset_n,
  lc3b_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  state_t      state, state_n;
  logic [15:0] pc, pc_n, req_addr, req_n, instr_buf, buf_n, if_pc, if_pc_n, rpc;
  assign rpc = bus.redirect_pc & 16'hFFFE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      instr_buf <= 16'h0000;
      if_pc     <= 16'h0000;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_addr  <= req_n;
      instr_buf <= buf_n;
      if_pc     <= if_pc_n;
    end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req_addr;
    buf_n   = instr_buf;
    if_pc_n = if_pc;
    case (state)
      IDLE: begin
        pc_n    = bus.redirect ? rpc : pc;
        req_n   = pc_n;
        state_n = FETCH;
      end
      FETCH:
        if (bus.redirect) begin
          pc_n    = rpc;
          req_n   = bus.imem_resp ? rpc : req_addr;
          state_n = bus.imem_resp ? FETCH : DRAIN;
        end else if (bus.imem_resp) begin
          buf_n   = bus.imem_rdata;
          if_pc_n = req_addr;
          pc_n    = req_addr + 16'd2;
          state_n = HOLD;
        end
      DRAIN: begin
        pc_n = bus.redirect ? rpc : pc;
        if (bus.imem_resp) begin
          req_n   = pc_n;
          state_n = FETCH;
        end
      end
      HOLD:
        if (bus.redirect) begin
          pc_n    = rpc;
          req_n   = rpc;
          state_n = FETCH;
        end else if (!bus.stall) begin
          req_n   = pc;
          state_n = FETCH;
        end
      default: state_n = IDLE;
    endcase
  end
  assign bus.imem_read    = (state == FETCH) || (state == DRAIN);
  assign bus.imem_address = req_addr;
  assign bus.if_valid     = state == HOLD;
  assign bus.if_instr     = instr_buf;
  assign bus.if_pc        = if_pc;
  assign bus.if_pc_plus2  = if_pc + 16'd2;
  assign bus.ir_load      = bus.if_valid & ~bus.stall & ~bus.redirect;
endmodule

// File: tb/tb_lc3b_fetch.sv
// tb_lc3b_fetch: scoreboard bench with a variable-latency memory model for lc3b_fetch
module tb_lc3b_fetch;
  typedef struct {logic [15:0] pc; logic [15:0] instr;} ld_t;
  logic        clk, reset_n;
  int          checks = 0, failures = 0;
  int          lat = 1, cnt = 0, cyc = 0, nloads = 0, last_ld = 0, prev_ld = 0;
  bit          busy = 0;
  logic [15:0] cur_addr = 0;
  logic        st = 0, rd = 0;
  logic [15:0] rdpc = 0;
  logic [15:0] exp_addr[$];
  ld_t         exp_load[$];
  lc3b_fetch_if bus();
  lc3b_fetch #(.RESET_PC(16'h3000)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push_fetch(input logic [15:0] a);
    exp_addr.push_back(a);
  endtask
  task automatic push_load(input logic [15:0] a);
    ld_t e;
    e.pc = a;
    e.instr = mem_word(a);
    exp_load.push_back(e);
  endtask
  task automatic cycle();
    ld_t e;
    logic [15:0] p2;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.imem_resp) begin
      busy = 0;
      bus.imem_resp = 0;
      bus.imem_rdata = 0;
    end
    if (bus.imem_read && !busy) begin
      if (exp_addr.size() == 0) check("spurious_read", {15'b0, bus.imem_read}, 16'd0);
      else check("imem_address", bus.imem_address, exp_addr.pop_front());
      busy = 1;
      cnt = 0;
      cur_addr = bus.imem_address;
    end else if (busy) begin
      check("read_held", {15'b0, bus.imem_read}, 16'd1);
      check("addr_stable", bus.imem_address, cur_addr);
    end
    if (busy && cnt == lat - 1) begin
      bus.imem_resp = 1;
      bus.imem_rdata = mem_word(cur_addr);
    end
    cnt++;
    bus.stall = st;
    bus.redirect = rd;
    bus.redirect_pc = rdpc;
    #1;
    if (bus.ir_load) begin
      if (exp_load.size() == 0) check("spurious_load", {15'b0, bus.ir_load}, 16'd0);
      else begin
        e = exp_load.pop_front();
        p2 = e.pc + 16'd2;
        check("if_pc", bus.if_pc, e.pc);
        check("if_instr", bus.if_instr, e.instr);
        check("if_pc_plus2", bus.if_pc_plus2, p2);
      end
      nloads++;
      prev_ld = last_ld;
      last_ld = cyc;
    end
  endtask
  task automatic do_reset();
    check("sb_addr_empty", 16'(exp_addr.size()), 16'd0);
    check("sb_load_empty", 16'(exp_load.size()), 16'd0);
    exp_addr.delete();
    exp_load.delete();
    st = 0; rd = 0; rdpc = 0;
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    busy = 0; bus.imem_resp = 0; bus.imem_rdata = 0;
    reset_n = 0;
    #1;
    check("rst_imem_read", {15'b0, bus.imem_read}, 16'd0);
    check("rst_if_valid", {15'b0, bus.if_valid}, 16'd0);
    check("rst_ir_load", {15'b0, bus.ir_load}, 16'd0);
    check("rst_if_instr", bus.if_instr, 16'h0000);
    check("rst_if_pc_plus2", bus.if_pc_plus2, 16'h0002);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask
  task automatic run_loads(input int n, input int budget);
    int start = nloads;
    for (int i = 0; i < budget && nloads - start < n; i++) cycle();
    check("loads_done", 16'(nloads - start), 16'(n));
  endtask
  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !bus.if_valid; i++) cycle();
    check("hold_valid", {15'b0, bus.if_valid}, 16'd1);
  endtask
  initial begin
    int n0;
    lat = 1;
    do_reset();
    push_fetch(16'h3000); push_fetch(16'h3002); push_fetch(16'h3004);
    push_load(16'h3000); push_load(16'h3002);
    run_loads(2, 20);
    check("throughput", 16'(last_ld - prev_ld), 16'd2);
    cycle();
    lat = 3;
    do_reset();
    push_fetch(16'h3000); push_fetch(16'h3002);
    push_load(16'h3000);
    st = 1;
    wait_valid(10);
    repeat (4) begin
      cycle();
      check("stall_read", {15'b0, bus.imem_read}, 16'd0);
      check("stall_pc", bus.if_pc, 16'h3000);
      check("stall_instr", bus.if_instr, mem_word(16'h3000));
      check("stall_ir_load", {15'b0, bus.ir_load}, 16'd0);
    end
    st = 0;
    n0 = nloads;
    cycle();
    check("single_load", 16'(nloads - n0), 16'd1);
    cycle();
    check("after_load_valid", {15'b0, bus.if_valid}, 16'd0);
    check("after_load_read", {15'b0, bus.imem_read}, 16'd1);
    check("single_load_2", 16'(nloads - n0), 16'd1);
    do_reset();
    push_fetch(16'h3000); push_fetch(16'h4000);
    push_load(16'h4000);
    cycle();
    rd = 1; rdpc = 16'h4001;
    cycle();
    rd = 0;
    cycle();
    check("drain_addr", bus.imem_address, 16'h3000);
    check("drain_ir_load", {15'b0, bus.ir_load}, 16'd0);
    cycle();
    run_loads(1, 10);
    lat = 2;
    do_reset();
    push_fetch(16'h3000); push_fetch(16'h5000); push_fetch(16'h5000);
    push_load(16'h5000);
    cycle();
    rd = 1; rdpc = 16'h5000;
    cycle();
    check("redir_resp_ir_load", {15'b0, bus.ir_load}, 16'd0);
    rd = 0; st = 1;
    wait_valid(10);
    check("hold_pc", bus.if_pc, 16'h5000);
    rd = 1;
    cycle();
    check("redir_hold_ir_load", {15'b0, bus.ir_load}, 16'd0);
    rd = 0; st = 0;
    cycle();
    check("redir_hold_valid", {15'b0, bus.if_valid}, 16'd0);
    run_loads(1, 10);
    lat = 1;
    do_reset();
    push_fetch(16'h3000); push_fetch(16'hFFFE); push_fetch(16'h0000);
    push_load(16'hFFFE);
    rd = 1; rdpc = 16'hFFFF;
    cycle();
    rd = 0;
    run_loads(1, 10);
    check("wrap_pc_plus2", bus.if_pc_plus2, 16'h0000);
    cycle();
    lat = 3;
    do_reset();
    push_fetch(16'h3000);
    cycle();
    cycle();
    do_reset();
    push_fetch(16'h3000);
    push_load(16'h3000);
    run_loads(1, 12);
    check("sb_addr_final", 16'(exp_addr.size()), 16'd0);
    check("sb_load_final", 16'(exp_load.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
